counter_param: RTL

COUNTER_PARAM -- requirements
Module: counter_param

---
 rtl/counter_param.sv | 85 ++++++++
 1 files changed

// File: rtl/counter_param.sv
// Parameterised up/down counter with a non-power-of-two modulus, a
// terminal-count flag, an overflow pulse and three terminal behaviours:
// wrap, saturate and one-shot.
module counter_param #(
  parameter int unsigned     WIDTH   = 16,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  // 0 = wrap, 1 = saturate, 2 = one-shot
  parameter int unsigned     MODE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_ena,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

  typedef enum logic {StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_clamped;
  logic             frozen;

  // Terminal depends on the current direction, so a direction change is
  // reflected in tc within the same cycle.
  assign tc = up_dn ? (count_q == MaxVal) : (count_q == '0);

  // Out-of-range load values are clamped so count never reaches MODULUS.
  assign load_clamped = (64'(load_val) >= MODULUS) ? MaxVal : load_val;

  // In one-shot mode the DONE state ignores count enables entirely.
  assign frozen = (MODE == 2) && (state_q == StDone);

  // Next-state logic: clear > load > count enable > hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    state_d = state_q;
    if (clear) begin
      count_d = '0;
      state_d = StRun;
    end else if (load) begin
      count_d = load_clamped;
      state_d = StRun;
    end else if (cnt_ena && !frozen) begin
      if (tc) begin
        ovf_d = 1'b1;
        if (MODE == 0) begin
          count_d = up_dn ? '0 : MaxVal;
        end else if (MODE == 2) begin
          state_d = StDone;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= StRun;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign done  = (MODE == 2) && (state_q == StDone);

endmodule
